// File: rtl/weight_settle_pkg.sv
// Shared widths and FSM state encoding for the weight_settle conditioner.
package weight_settle_pkg;

    localparam int unsigned WEIGHT_W = 12;
    localparam int unsigned COUNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/weight_settle_sat_counter.sv
// Clearable up-counter that loads 1, saturates at TERMINAL and flags the last step before it.
module sat_counter #(
    parameter int unsigned TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic last_c
);

    localparam int unsigned CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (inc && (cnt != CW'(TERMINAL))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // High when one more qualifying sample reaches the terminal count.
    assign last_c = (cnt == CW'(TERMINAL - 1));

endmodule

// File: rtl/weight_settle.sv
// Debounces a noisy scale reading into one constant weight plateau per item for the sorter.
module weight_settle
    import weight_settle_pkg::*;
#(
    parameter int unsigned WIDTH         = WEIGHT_W,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TOL           = 2,
    parameter int unsigned ZERO_THRESH   = 0,
    parameter int unsigned ZERO_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   raw_weight,
    output logic [WIDTH-1:0]   weight,
    output logic               item_valid,
    output logic [COUNT_W-1:0] item_count,
    output logic               busy
);

    localparam logic [WIDTH:0] EMPTY_LIM = (WIDTH + 1)'(ZERO_THRESH + 1);
    localparam logic [WIDTH:0] TOL_W     = (WIDTH + 1)'(TOL);

    state_t           state;
    logic [WIDTH-1:0] cand;
    logic [WIDTH:0]   raw_x;
    logic [WIDTH:0]   cand_x;
    logic [WIDTH:0]   diff_c;
    logic             empty_c;
    logic             in_tol_c;
    logic             scnt_clr, scnt_load, scnt_inc, scnt_last_c;
    logic             zcnt_clr, zcnt_load, zcnt_inc, zcnt_last_c;

    // Sample classification; difference taken one bit wider so it never wraps.
    assign raw_x    = {1'b0, raw_weight};
    assign cand_x   = {1'b0, cand};
    assign empty_c  = (raw_x < EMPTY_LIM);
    assign diff_c   = (raw_x >= cand_x) ? (raw_x - cand_x) : (cand_x - raw_x);
    assign in_tol_c = (diff_c <= TOL_W);

    // Counter control derived from the current state and sample.
    always_comb begin
        scnt_clr  = 1'b0;
        scnt_load = 1'b0;
        scnt_inc  = 1'b0;
        zcnt_clr  = 1'b0;
        zcnt_load = 1'b0;
        zcnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                scnt_load = !empty_c;
            end
            SETTLE: begin
                if (empty_c)             scnt_clr  = 1'b1;
                else if (!in_tol_c)      scnt_load = 1'b1;
                else if (!scnt_last_c)   scnt_inc  = 1'b1;
                else                     scnt_clr  = 1'b1;
            end
            HELD: begin
                zcnt_load = empty_c;
            end
            RELEASE: begin
                if (!empty_c)            zcnt_clr = 1'b1;
                else if (!zcnt_last_c)   zcnt_inc = 1'b1;
                else                     zcnt_clr = 1'b1;
            end
        endcase
    end

    sat_counter #(.TERMINAL(STABLE_CYCLES)) u_scnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (scnt_clr),
        .load   (scnt_load),
        .inc    (scnt_inc),
        .last_c (scnt_last_c)
    );

    sat_counter #(.TERMINAL(ZERO_CYCLES)) u_zcnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (zcnt_clr),
        .load   (zcnt_load),
        .inc    (zcnt_inc),
        .last_c (zcnt_last_c)
    );

    // State, candidate and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cand       <= '0;
            weight     <= '0;
            item_valid <= 1'b0;
            item_count <= '0;
            busy       <= 1'b0;
        end else begin
            item_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty_c) begin
                        cand  <= raw_weight;
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (empty_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!in_tol_c) begin
                        cand <= raw_weight;
                    end else if (scnt_last_c) begin
                        state      <= HELD;
                        weight     <= cand;
                        item_valid <= 1'b1;
                        item_count <= item_count + COUNT_W'(1);
                    end
                end
                HELD: begin
                    if (empty_c) state <= RELEASE;
                end
                RELEASE: begin
                    if (!empty_c) begin
                        state <= HELD;
                    end else if (zcnt_last_c) begin
                        state  <= IDLE;
                        weight <= '0;
                        busy   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
